// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  // Word accesses only, and no wrap-around past the top of memory.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned mem_size);
    return (addr[1:0] == 2'b00) && (addr <= 32'(mem_size - 4));
  endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Winner select with starvation counters; DMEM_ARB_RR_EN selects round-robin
// priority, otherwise A has fixed priority over B.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [3:0] wait_a;
  logic [3:0] wait_b;
  port_t      prefer;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (a_req && b_req) begin
      if (wait_a >= WAIT_LIM)      a_gnt = 1'b1;
      else if (wait_b >= WAIT_LIM) b_gnt = 1'b1;
      else if (prefer == PORT_B)   b_gnt = 1'b1;
      else                         a_gnt = 1'b1;
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_a <= '0;
      wait_b <= '0;
    end else begin
      if (!a_req || a_gnt)        wait_a <= '0;
      else if (wait_a < WAIT_LIM) wait_a <= wait_a + 4'd1;
      if (!b_req || b_gnt)        wait_b <= '0;
      else if (wait_b < WAIT_LIM) wait_b <= wait_b + 4'd1;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Only contended grants move the pointer; it then favours the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              prefer <= PORT_A;
    else if (a_req && b_req) prefer <= a_gnt ? PORT_B : PORT_A;
  end
`else
  assign prefer = PORT_A;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory; build with
// DMEM_ARB_RR_EN for round-robin priority instead of fixed A-over-B.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic        b_err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  logic        any_gnt;
  logic        sel_we;
  logic        sel_legal;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  resp_t       resp_d;
  resp_t       resp_q;
  port_t       resp_port_d;
  port_t       resp_port_q;

  dmem_arb_prio #(
    .MAX_WAIT(MAX_WAIT)
  ) u_prio (
    .clk  (clk),
    .rst_n(rst_n),
    .a_req(a_req),
    .b_req(b_req),
    .a_gnt(a_gnt),
    .b_gnt(b_gnt)
  );

  always_comb begin
    any_gnt     = a_gnt | b_gnt;
    sel_we      = b_gnt ? b_we    : a_we;
    sel_addr    = b_gnt ? b_addr  : a_addr;
    sel_wdata   = b_gnt ? b_wdata : a_wdata;
    sel_legal   = addr_legal(sel_addr, MEM_SIZE);
    mem_addr    = any_gnt ? sel_addr  : '0;
    mem_wdata   = any_gnt ? sel_wdata : '0;
    mem_read    = any_gnt & sel_legal & ~sel_we;
    mem_write   = any_gnt & sel_legal & sel_we;
    resp_d.valid = any_gnt;
    resp_d.err   = any_gnt & ~sel_legal;
    resp_d.data  = mem_read ? mem_rdata : '0;
    resp_port_d  = b_gnt ? PORT_B : PORT_A;
  end

  // Data only changes on a response so it holds between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q      <= '0;
      resp_port_q <= PORT_A;
    end else begin
      resp_q.valid <= resp_d.valid;
      resp_q.err   <= resp_d.err;
      resp_port_q  <= resp_port_d;
      if (any_gnt) resp_q.data <= resp_d.data;
    end
  end

  assign a_rvalid = resp_q.valid && (resp_port_q == PORT_A);
  assign a_err    = resp_q.err   && (resp_port_q == PORT_A);
  assign b_rvalid = resp_q.valid && (resp_port_q == PORT_B);
  assign b_err    = resp_q.err   && (resp_port_q == PORT_B);
  assign rdata    = resp_q.data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a behavioural model of arbitration, legality and memory.
module tb_dmem_arbiter;

  localparam int unsigned MEM_SIZE = 32;
  localparam int unsigned MAX_WAIT = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [8];
  logic        init_done = 1'b0;
  logic [31:0] ref_mem [8];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (mem_write) begin
      mem[mem_addr[4:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[4:2]];

  dmem_arbiter #(
    .MEM_SIZE(MEM_SIZE),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  task automatic idle_cycle();
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({a_rvalid, a_err, b_rvalid, b_err, a_gnt, b_gnt, mem_read, mem_write} !== 8'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000000",
               {a_rvalid, a_err, b_rvalid, b_err, a_gnt, b_gnt, mem_read, mem_write});
    end
    checks++;
    if ({rdata, mem_addr} !== 64'b0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h want 0", rdata, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    init_done = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h08; a_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({a_gnt, b_gnt, mem_write, mem_read} !== 4'b1010 || mem_addr !== 32'h08 || mem_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_strobe: gnt/wr/rd=%b addr=%h wdata=%h want 1010 08 deadbeef",
               {a_gnt, b_gnt, mem_write, mem_read}, mem_addr, mem_wdata);
    end
    ref_mem[2] = 32'hDEADBEEF;
    @(posedge clk); #1;
    checks++;
    if ({a_rvalid, a_err, b_rvalid} !== 3'b100 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL wr_resp: rv/err/brv=%b rdata=%h want 100 0", {a_rvalid, a_err, b_rvalid}, rdata);
    end
    @(negedge clk);
    a_we = 1'b0;
    #1;
    checks++;
    if ({a_gnt, mem_write, mem_read} !== 3'b101 || mem_addr !== 32'h08) begin
      failures++;
      $display("FAIL rd_strobe: gnt/wr/rd=%b addr=%h want 101 08", {a_gnt, mem_write, mem_read}, mem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({a_rvalid, a_err} !== 2'b10 || rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_resp: rv/err=%b rdata=%h want 10 deadbeef", {a_rvalid, a_err}, rdata);
    end
    @(negedge clk);
    a_req = 1'b0;
    #1;
    checks++;
    if ({a_gnt, b_gnt, mem_read, mem_write} !== 4'b0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL idle_bus: gnt/rd/wr=%b addr=%h want 0000 0", {a_gnt, b_gnt, mem_read, mem_write}, mem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (a_rvalid !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rdata_hold: rv=%b rdata=%h want 0 deadbeef", a_rvalid, rdata);
    end
  endtask

  task automatic test_legality();
    logic        port_b [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        wr     [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] addr   [6] = '{32'h06, 32'h1D, 32'h1C, 32'h1C, 32'hFFFF_FFFC, 32'h20};
    logic        err    [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] data   [6] = '{32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a_req = !port_b[i]; b_req = port_b[i];
      a_we = wr[i]; b_we = wr[i];
      a_addr = addr[i]; b_addr = addr[i];
      a_wdata = 32'h1234_5678; b_wdata = 32'h1234_5678;
      #1;
      checks++;
      if ({a_gnt, b_gnt} !== {!port_b[i], port_b[i]} ||
          {mem_write, mem_read} !== {!err[i] && wr[i], !err[i] && !wr[i]}) begin
        failures++;
        $display("FAIL legal_strobe[%0d]: gnt=%b wr/rd=%b want %b %b", i, {a_gnt, b_gnt},
                 {mem_write, mem_read}, {!port_b[i], port_b[i]}, {!err[i] && wr[i], !err[i] && !wr[i]});
      end
      if (!err[i] && wr[i]) ref_mem[int'(addr[i] >> 2)] = 32'h1234_5678;
      @(posedge clk); #1;
      checks++;
      if ({a_rvalid, a_err, b_rvalid, b_err} !== {!port_b[i], !port_b[i] && err[i], port_b[i], port_b[i] && err[i]} ||
          rdata !== data[i]) begin
        failures++;
        $display("FAIL legal_resp[%0d]: rv/err=%b rdata=%h want %b %h", i,
                 {a_rvalid, a_err, b_rvalid, b_err}, rdata,
                 {!port_b[i], !port_b[i] && err[i], port_b[i], port_b[i] && err[i]}, data[i]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_contention();
    logic exp_a;
    @(negedge clk);
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    a_addr = 32'h08; b_addr = 32'h1C;
    for (int i = 0; i < 10; i++) begin
      if (RR_MODE) exp_a = (i % 2) == 0;
      else         exp_a = (i % (MAX_WAIT + 1)) != MAX_WAIT;
      #1;
      checks++;
      if ({a_gnt, b_gnt} !== {exp_a, !exp_a}) begin
        failures++;
        $display("FAIL contend_gnt[%0d]: got %b want %b", i, {a_gnt, b_gnt}, {exp_a, !exp_a});
      end
      @(posedge clk); #1;
      checks++;
      if ({a_rvalid, b_rvalid} !== {exp_a, !exp_a} || rdata !== (exp_a ? 32'hDEADBEEF : 32'h1234_5678)) begin
        failures++;
        $display("FAIL contend_resp[%0d]: rv=%b rdata=%h want %b", i, {a_rvalid, b_rvalid}, rdata, {exp_a, !exp_a});
      end
      @(negedge clk);
    end
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    a_addr = 32'h08; b_addr = 32'h1C;
    @(posedge clk); #1;
    checks++;
    if (a_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_rv: got %b want 1", a_rvalid);
    end
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_rvalid, a_err, b_rvalid, b_err} !== 4'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: rv/err=%b rdata=%h want 0000 0", {a_rvalid, a_err, b_rvalid, b_err}, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_req = 1'b1; b_req = 1'b1;
    #1;
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL post_reset_gnt: got %b want 10", {a_gnt, b_gnt});
    end
    @(posedge clk); #1;
    checks++;
    if ({a_rvalid, a_err, b_rvalid} !== 3'b100 || rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL post_reset_resp: rv=%b rdata=%h want 100 deadbeef", {a_rvalid, a_err, b_rvalid}, rdata);
    end
    idle_cycle();
  endtask

  task automatic gen_access(output logic we, output logic [31:0] addr, output logic [31:0] wdata);
    we = ($urandom_range(0, 1) == 1);
    wdata = $urandom;
    case ($urandom_range(0, 9))
      0:       addr = 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(1, 3));
      1:       addr = 32'(MEM_SIZE) + 32'($urandom_range(0, 3)) * 32'd4;
      2:       addr = 32'hFFFF_FFFC;
      default: addr = 32'($urandom_range(0, 7)) * 32'd4;
    endcase
  endtask

  task automatic test_random();
    int unsigned wa = 0, wb = 0;
    logic        pref_b = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [3:0]  exp_resp;
    logic        ea, eb, we, legal;
    logic [31:0] addr, wd;
    @(negedge clk);
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!a_req && $urandom_range(0, 3) != 0) begin
        gen_access(a_we, a_addr, a_wdata);
        a_req = 1'b1;
      end
      if (!b_req && $urandom_range(0, 3) != 0) begin
        gen_access(b_we, b_addr, b_wdata);
        b_req = 1'b1;
      end
      #1;
      ea = 1'b0; eb = 1'b0;
      if (a_req && b_req) begin
        if (wa >= MAX_WAIT)           ea = 1'b1;
        else if (wb >= MAX_WAIT)      eb = 1'b1;
        else if (RR_MODE && pref_b)   eb = 1'b1;
        else                          ea = 1'b1;
        if (RR_MODE) pref_b = ea;
      end else begin
        ea = a_req; eb = b_req;
      end
      checks++;
      if ({a_gnt, b_gnt} !== {ea, eb}) begin
        failures++;
        $display("FAIL rand_gnt[%0d]: got %b want %b", cyc, {a_gnt, b_gnt}, {ea, eb});
      end
      exp_resp = 4'b0;
      if (ea || eb) begin
        addr  = eb ? b_addr : a_addr;
        we    = eb ? b_we : a_we;
        wd    = eb ? b_wdata : a_wdata;
        legal = (addr % 4 == 0) && (addr <= 32'(MEM_SIZE - 4));
        checks++;
        if ({mem_write, mem_read} !== {legal && we, legal && !we} || (legal && mem_addr !== addr) ||
            (legal && we && mem_wdata !== wd)) begin
          failures++;
          $display("FAIL rand_strobe[%0d]: wr/rd=%b addr=%h wdata=%h want %b %h %h", cyc,
                   {mem_write, mem_read}, mem_addr, mem_wdata, {legal && we, legal && !we}, addr, wd);
        end
        exp_rdata = (legal && !we) ? ref_mem[int'(addr >> 2)] : 32'h0;
        if (legal && we) ref_mem[int'(addr >> 2)] = wd;
        exp_resp = {ea, ea && !legal, eb, eb && !legal};
      end else begin
        checks++;
        if ({mem_write, mem_read} !== 2'b0 || mem_addr !== 32'h0) begin
          failures++;
          $display("FAIL rand_idle[%0d]: wr/rd=%b addr=%h want 00 0", cyc, {mem_write, mem_read}, mem_addr);
        end
      end
      wa = (a_req && !ea) ? ((wa < MAX_WAIT) ? wa + 1 : wa) : 0;
      wb = (b_req && !eb) ? ((wb < MAX_WAIT) ? wb + 1 : wb) : 0;
      @(posedge clk); #1;
      checks++;
      if ({a_rvalid, a_err, b_rvalid, b_err} !== exp_resp || rdata !== exp_rdata) begin
        failures++;
        $display("FAIL rand_resp[%0d]: rv/err=%b rdata=%h want %b %h", cyc,
                 {a_rvalid, a_err, b_rvalid, b_err}, rdata, exp_resp, exp_rdata);
      end
      if (ea) a_req = 1'b0;
      if (eb) b_req = 1'b0;
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_legality();
    test_contention();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
